// File: rtl/fft_butterfly_stage2.sv
// Second radix-2 DIF stage of the 8-point FFT: buffers a frame, runs (0,2)(1,3)(4,6)(5,7) butterflies.
// Latency: first output visible 5 edges after the 8th input is accepted (4 calc cycles + output register).
// Backpressure: input ready only while loading; a low ready_i freezes the output beat indefinitely.
// Build option: define FFT_STAGE2_SCALE_EN to halve every result component (no overflow);
// without it the low DATA_WIDTH/2 bits are kept and overflow wraps in two's complement.
module fft_butterfly_stage2 #(
    parameter int DATA_WIDTH = 50,
    parameter int FRAME_LEN  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] signal_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] signal_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    localparam int HW = DATA_WIDTH / 2;
    localparam int EW = HW + 1;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    // The butterfly pairing and counter widths are hard-wired for 8 samples.
    generate
        if (FRAME_LEN != 8) begin : g_bad_frame_len
            $error("fft_butterfly_stage2: FRAME_LEN must be 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CALC  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]            r_in_cnt;
    logic [1:0]            r_calc_cnt;
    logic [2:0]            r_out_cnt;
    logic [DATA_WIDTH-1:0] r_signal_o;
    logic                  r_valid_o;
    logic                  r_last_o;

    logic [DATA_WIDTH-1:0] r_in_buf  [0:7];
    logic [DATA_WIDTH-1:0] r_out_buf [0:7];

    logic w_in_fire;
    logic w_out_fire;

    assign ready_o    = (r_state == S_LOAD);
    assign w_in_fire  = valid_i && (r_state == S_LOAD);
    assign w_out_fire = r_valid_o && ready_i;
    assign signal_o   = r_signal_o;
    assign valid_o    = r_valid_o;
    assign last_o     = r_last_o;

    // Result width reduction for one component of a DATA_WIDTH/2+1 bit intermediate.
`ifdef FFT_STAGE2_SCALE_EN
    function automatic logic [HW-1:0] reduce(input logic signed [EW-1:0] v);
        return HW'(v >>> 1);
    endfunction
`else
    function automatic logic [HW-1:0] reduce(input logic signed [EW-1:0] v);
        return HW'(v);
    endfunction
`endif

    // Butterfly operands: k selects pair (a, a+2) with a in {0,1,4,5}.
    logic [2:0]            w_idx_a;
    logic [2:0]            w_idx_b;
    logic [DATA_WIDTH-1:0] w_x_a;
    logic [DATA_WIDTH-1:0] w_x_b;
    logic signed [EW-1:0]  w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [EW-1:0]  w_s_re, w_s_im, w_d_re, w_d_im;
    logic signed [EW-1:0]  w_t_re, w_t_im;
    logic [DATA_WIDTH-1:0] w_y_a;
    logic [DATA_WIDTH-1:0] w_y_b;

    assign w_idx_a = {r_calc_cnt[1], 1'b0, r_calc_cnt[0]};
    assign w_idx_b = {r_calc_cnt[1], 1'b1, r_calc_cnt[0]};
    assign w_x_a   = r_in_buf[w_idx_a];
    assign w_x_b   = r_in_buf[w_idx_b];

    assign w_a_re = {w_x_a[DATA_WIDTH-1], w_x_a[DATA_WIDTH-1:HW]};
    assign w_a_im = {w_x_a[HW-1], w_x_a[HW-1:0]};
    assign w_b_re = {w_x_b[DATA_WIDTH-1], w_x_b[DATA_WIDTH-1:HW]};
    assign w_b_im = {w_x_b[HW-1], w_x_b[HW-1:0]};

    assign w_s_re = w_a_re + w_b_re;
    assign w_s_im = w_a_im + w_b_im;
    assign w_d_re = w_a_re - w_b_re;
    assign w_d_im = w_a_im - w_b_im;

    // Twiddle: identity for even k, multiply by -j for odd k (re'=im, im'=-re).
    always_comb begin
        w_t_re = w_d_re;
        w_t_im = w_d_im;
        if (r_calc_cnt[0]) begin
            w_t_re = w_d_im;
            w_t_im = -w_d_re;
        end
    end

    assign w_y_a = {reduce(w_s_re), reduce(w_s_im)};
    assign w_y_b = {reduce(w_t_re), reduce(w_t_im)};

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: load 8, compute 4 pairs, drain 8.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_in_fire && (r_in_cnt == LAST_IDX)) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_calc_cnt == 2'd3) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_fire && (r_out_cnt == LAST_IDX)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Counters and the registered output beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_in_cnt   <= 3'd0;
            r_calc_cnt <= 2'd0;
            r_out_cnt  <= 3'd0;
            r_signal_o <= '0;
            r_valid_o  <= 1'b0;
            r_last_o   <= 1'b0;
        end else begin
            // in_cnt wraps to 0 on the 8th accept.
            if (w_in_fire) begin
                r_in_cnt <= r_in_cnt + 3'd1;
            end
            // calc_cnt wraps to 0 after pair k3.
            if (r_state == S_CALC) begin
                r_calc_cnt <= r_calc_cnt + 2'd1;
            end
            if (r_state == S_DRAIN) begin
                if (!r_valid_o) begin
                    // First drain cycle: present out_buf[0].
                    r_signal_o <= r_out_buf[r_out_cnt];
                    r_valid_o  <= 1'b1;
                    r_last_o   <= (r_out_cnt == LAST_IDX);
                end else if (ready_i) begin
                    if (r_out_cnt == LAST_IDX) begin
                        r_out_cnt <= 3'd0;
                        r_valid_o <= 1'b0;
                        r_last_o  <= 1'b0;
                    end else begin
                        r_out_cnt  <= r_out_cnt + 3'd1;
                        r_signal_o <= r_out_buf[r_out_cnt + 3'd1];
                        r_last_o   <= ((r_out_cnt + 3'd1) == LAST_IDX);
                    end
                end
            end
        end
    end

    // Frame buffers; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (w_in_fire) begin
            r_in_buf[r_in_cnt] <= signal_i;
        end
        if (r_state == S_CALC) begin
            r_out_buf[w_idx_a] <= w_y_a;
            r_out_buf[w_idx_b] <= w_y_b;
        end
    end

endmodule

// File: tb/tb_fft_butterfly_stage2.sv
// Directed bench for fft_butterfly_stage2 with hand-computed expected frames.
module tb_fft_butterfly_stage2;

    logic        clk;
    logic        rst_ni;
    logic [49:0] signal_i;
    logic        valid_i;
    logic        ready_o;
    logic [49:0] signal_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;

    int checks = 0;
    int errors = 0;

    logic [49:0] in_vec  [8];
    logic [49:0] exp_vec [8];
    logic [49:0] cap_dat [8];
    logic        cap_last[8];
    int          first_acc;
    int          first_wait;
    int          rdy_hi;

    fft_butterfly_stage2 #(.DATA_WIDTH(50), .FRAME_LEN(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .signal_i(signal_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .signal_o(signal_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [49:0] mk(input int re, input int im);
        return {re[24:0], im[24:0]};
    endfunction

    task automatic set_ramp();
        for (int i = 0; i < 8; i++) in_vec[i] = mk(i + 1, 0);
        exp_vec[0] = mk(4, 0);   exp_vec[1] = mk(6, 0);
        exp_vec[2] = mk(-2, 0);  exp_vec[3] = mk(0, 2);
        exp_vec[4] = mk(12, 0);  exp_vec[5] = mk(14, 0);
        exp_vec[6] = mk(-2, 0);  exp_vec[7] = mk(0, 2);
    endtask

    // Drive in_vec; accepted beats are counted at the edge following a negedge with valid&&ready.
    task automatic send_frame(input bit gaps);
        int  i     = 0;
        int  guard = 0;
        bit  tog   = 1'b0;
        bit  acc;
        first_acc = -1;
        while (i < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (gaps && tog) begin
                valid_i = 1'b0;
            end else begin
                valid_i  = 1'b1;
                signal_i = in_vec[i];
            end
            tog = !tog;
            acc = valid_i && ready_o;
            if (acc && first_acc < 0) first_acc = guard;
            @(posedge clk);
            if (acc) i++;
        end
        if (i < 8) begin
            checks++;
            errors++;
            $display("FAIL send_timeout accepted %0d required 8", i);
        end
    endtask

    // Record 8 output beats with ready_i high; optionally keep garbage valid on the input.
    task automatic capture(input bit hold);
        int n     = 0;
        int guard = 0;
        bit acc;
        first_wait = -1;
        rdy_hi     = 0;
        ready_i    = 1'b1;
        while (n < 8 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (hold) begin
                valid_i  = 1'b1;
                signal_i = 50'h2_AAAA_5555_1234;
            end else begin
                valid_i = 1'b0;
            end
            if (ready_o) rdy_hi++;
            acc = valid_o;
            if (valid_o) begin
                if (first_wait < 0) first_wait = guard;
                cap_dat[n]  = signal_o;
                cap_last[n] = last_o;
            end
            @(posedge clk);
            if (acc) n++;
        end
        if (n < 8) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout got %0d beats required 8", n);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; signal_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", ready_o); end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", valid_o); end
        checks++;
        if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b required 0", last_o); end
        checks++;
        if (signal_o !== 50'd0) begin errors++; $display("FAIL reset_signal got %h required 0", signal_o); end
    endtask

    task automatic test_ramp();
        set_ramp();
        send_frame(1'b0);
        capture(1'b0);
        checks++;
        if (first_wait !== 6) begin errors++; $display("FAIL ramp_latency got %0d required 6", first_wait); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_dat[j] !== exp_vec[j]) begin
                errors++; $display("FAIL ramp_dat[%0d] got %h required %h", j, cap_dat[j], exp_vec[j]);
            end
            checks++;
            if (cap_last[j] !== (j == 7)) begin
                errors++; $display("FAIL ramp_last[%0d] got %b required %b", j, cap_last[j], (j == 7));
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int guard = 0;
        int stalls = 0;
        bit acc;
        set_ramp();
        send_frame(1'b0);
        while (n < 8 && guard < 300) begin
            @(negedge clk);
            guard++;
            valid_i = 1'b0;
            acc = 1'b0;
            if (valid_o) begin
                if (n == 2 && stalls < 3) begin
                    ready_i = 1'b0;
                    stalls++;
                    checks++;
                    if (signal_o !== exp_vec[2]) begin
                        errors++; $display("FAIL bp_hold_dat got %h required %h", signal_o, exp_vec[2]);
                    end
                end else begin
                    ready_i = 1'b1;
                    acc = 1'b1;
                    cap_dat[n] = signal_o;
                end
            end
            @(posedge clk);
            if (acc) n++;
        end
        checks++;
        if (n !== 8 || stalls !== 3) begin
            errors++; $display("FAIL bp_count got beats %0d stalls %0d required 8 and 3", n, stalls);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_dat[j] !== exp_vec[j]) begin
                errors++; $display("FAIL bp_dat[%0d] got %h required %h", j, cap_dat[j], exp_vec[j]);
            end
        end
        ready_i = 1'b1;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) in_vec[i] = '0;
        in_vec[0] = mk(16777215, 0);
        in_vec[2] = mk(16777215, 0);
        for (int i = 0; i < 8; i++) exp_vec[i] = '0;
`ifdef FFT_STAGE2_SCALE_EN
        exp_vec[0] = mk(16777215, 0);
`else
        exp_vec[0] = mk(-2, 0);
`endif
        send_frame(1'b0);
        capture(1'b0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_dat[j] !== exp_vec[j]) begin
                errors++; $display("FAIL ovf_dat[%0d] got %h required %h", j, cap_dat[j], exp_vec[j]);
            end
        end
    endtask

    task automatic test_gaps();
        set_ramp();
        send_frame(1'b1);
        capture(1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (rdy_hi !== 0) begin errors++; $display("FAIL gaps_ready_high got %0d cycles required 0", rdy_hi); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_dat[j] !== exp_vec[j]) begin
                errors++; $display("FAIL gaps_dat[%0d] got %h required %h", j, cap_dat[j], exp_vec[j]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int n = 0;
        int guard = 0;
        bit acc;
        set_ramp();
        send_frame(1'b0);
        ready_i = 1'b1;
        while (n < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
            valid_i = 1'b0;
            acc = valid_o;
            @(posedge clk);
            if (acc) n++;
        end
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid valid %b ready %b required 0 1", valid_o, ready_o);
        end
        for (int i = 0; i < 8; i++) in_vec[i] = mk(1, 1);
        for (int i = 0; i < 8; i++) exp_vec[i] = ((i % 4) < 2) ? mk(2, 2) : mk(0, 0);
        send_frame(1'b0);
        capture(1'b0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_dat[j] !== exp_vec[j]) begin
                errors++; $display("FAIL rst_mid_dat[%0d] got %h required %h", j, cap_dat[j], exp_vec[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_ramp();
        send_frame(1'b0);
        capture(1'b1);
        send_frame(1'b0);
        checks++;
        if (first_acc !== 1) begin errors++; $display("FAIL b2b_gap got %0d cycles required 1", first_acc); end
        capture(1'b0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cap_dat[j] !== exp_vec[j]) begin
                errors++; $display("FAIL b2b_dat[%0d] got %h required %h", j, cap_dat[j], exp_vec[j]);
            end
        end
        checks++;
        if (cap_last[7] !== 1'b1 || cap_last[6] !== 1'b0) begin
            errors++; $display("FAIL b2b_last got %b%b required 01", cap_last[6], cap_last[7]);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_overflow();
        test_gaps();
        test_reset_mid_drain();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
